spi_frame_ctrl: RTL and testbench

Frame-level controller that sits above the SPI byte engine (SPI_COMM) in the USB3300 sniffer. It counts bytes within each SS-framed transaction and decodes the header command. It sequences accesses to an internal configuration register bank, the sniffer capture FIFO and a status byte. It supplies the next MISO byte and raises a frame error back to the byte engine.

---
 rtl/spi_frame_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// Frame-level controller above the SPI byte engine.
// Decodes the header byte of each SS-framed transaction, then runs one of
// these accesses: configuration register write or read, capture FIFO read,
// or status read. It also supplies the next MISO byte and reports frame errors.
//
// Byte strobe protocol: spi_eob is a one-cycle strobe and spi_rx is valid only
// while it is high. The byte engine gives no backpressure. Every strobe seen
// inside a frame is consumed in that cycle, and the reply for the next slot
// appears on spi_tx one cycle later.
module spi_frame_ctrl #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_busy,
  input  logic               spi_eob,
  input  logic [7:0]         spi_rx,
  output logic [7:0]         spi_tx,
  output logic               spi_err,
  input  logic [7:0]         fifo_data,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  output logic               fifo_rd,
  output logic [8*NREGS-1:0] cfg_regs,
  output logic               cfg_wr,
  output logic [7:0]         frame_cnt,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ARG   = 3'd2,
    S_DATA  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state, state_n;
  logic            busy_q;
  logic [7:0]      regs [NREGS];
  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_nxt;
  logic [1:0]      cmd_q;
  logic            rd_q;
  logic            unf, err;
  logic            fifo_rd_q;
  logic [7:0]      byte_idx;

  // Header decode, meaningful only while spi_eob is high in HDR.
  logic [4:0]      hdr_cmd;
  logic            hdr_rd;
  logic            hdr_valid;
  logic            frame_end;
  logic [7:0]      status_byte;

  // Per-strobe actions produced by the datapath decode.
  logic            tx_ld;
  logic [7:0]      tx_val;
  logic            pop, unf_set, err_set, stat_clr;
  logic            reg_we, addr_ld, addr_inc;
  logic            fifo_slot, stat_slot;

  assign hdr_cmd     = spi_rx[4:0];
  assign hdr_rd      = spi_rx[6];
  assign hdr_valid   = (hdr_cmd == 5'd0) || (hdr_cmd == 5'd1) ||
                       (((hdr_cmd == 5'd2) || (hdr_cmd == 5'd3)) && hdr_rd);
  assign frame_end   = (state != S_IDLE) && !spi_busy;
  assign addr_nxt    = addr + AW'(1);
  assign status_byte = {fifo_empty, fifo_full, unf, err, frame_cnt[3:0]};
  assign fifo_rd     = fifo_rd_q & ~fifo_empty;
  assign fsm_state   = state;

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign cfg_regs[8*i +: 8] = regs[i];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; a falling spi_busy ends the frame from any active state.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (spi_busy && !busy_q) state_n = S_HDR;
      S_HDR: begin
        if (spi_eob) begin
          if (!hdr_valid)             state_n = S_ERR;
          else if (hdr_cmd == 5'd0)   state_n = S_DRAIN;
          else if (hdr_cmd == 5'd1)   state_n = S_ARG;
          else                        state_n = S_DATA;
        end
      end
      S_ARG:   if (spi_eob) state_n = S_DATA;
      default: state_n = state;
    endcase
    if (frame_end) state_n = S_IDLE;
  end

  // Per-strobe datapath decode: register access, next MISO byte, pops, sticky bits.
  always_comb begin
    tx_ld     = 1'b0;
    tx_val    = 8'h00;
    pop       = 1'b0;
    unf_set   = 1'b0;
    err_set   = 1'b0;
    stat_clr  = 1'b0;
    reg_we    = 1'b0;
    addr_ld   = 1'b0;
    addr_inc  = 1'b0;
    fifo_slot = 1'b0;
    stat_slot = 1'b0;
    if (spi_eob) begin
      case (state)
        S_HDR: begin
          tx_ld = 1'b1;
          if (!hdr_valid)            err_set   = 1'b1;
          else if (hdr_cmd == 5'd2)  fifo_slot = 1'b1;
          else if (hdr_cmd == 5'd3)  stat_slot = 1'b1;
        end
        S_ARG: begin
          addr_ld = 1'b1;
          tx_ld   = 1'b1;
          if (rd_q) tx_val = regs[spi_rx[AW-1:0]];
        end
        S_DATA: begin
          addr_inc = 1'b1;
          tx_ld    = 1'b1;
          case (cmd_q)
            2'd1:    if (rd_q) tx_val = regs[addr_nxt];
                     else      reg_we = 1'b1;
            2'd2:    fifo_slot = 1'b1;
            2'd3:    stat_slot = 1'b1;
            default: tx_val = 8'h00;
          endcase
        end
        S_DRAIN, S_ERR: tx_ld = 1'b1;
        default: tx_ld = 1'b0;
      endcase
    end
    // Loads that consume FIFO data or sticky bits are skipped when the frame
    // ends on this very strobe, since that byte would never be shifted out.
    if (fifo_slot && spi_busy) begin
      if (!fifo_empty) begin
        tx_val = fifo_data;
        pop    = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
    if (stat_slot && spi_busy) begin
      tx_val   = status_byte;
      stat_clr = 1'b1;
    end
  end

  // Datapath registers: register bank, address, MISO byte, sticky bits, counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      busy_q    <= 1'b0;
      addr      <= '0;
      cmd_q     <= 2'd0;
      rd_q      <= 1'b0;
      unf       <= 1'b0;
      err       <= 1'b0;
      fifo_rd_q <= 1'b0;
      cfg_wr    <= 1'b0;
      spi_tx    <= 8'h00;
      spi_err   <= 1'b0;
      frame_cnt <= 8'h00;
      byte_idx  <= 8'h00;
    end else begin
      busy_q    <= spi_busy;
      cfg_wr    <= reg_we;
      fifo_rd_q <= pop;
      unf       <= unf_set | (unf & ~stat_clr);
      err       <= err_set | (err & ~stat_clr);
      if (reg_we) regs[addr] <= spi_rx;
      if (addr_ld)       addr <= spi_rx[AW-1:0];
      else if (addr_inc) addr <= addr_nxt;
      if ((state == S_HDR) && spi_eob && hdr_valid) begin
        cmd_q <= spi_rx[1:0];
        rd_q  <= hdr_rd;
      end
      if (frame_end) begin
        spi_tx   <= 8'h00;
        spi_err  <= 1'b0;
        byte_idx <= 8'h00;
        if ((state != S_ERR) && !err_set) frame_cnt <= frame_cnt + 8'd1;
      end else begin
        if (tx_ld)   spi_tx  <= tx_val;
        if (err_set) spi_err <= 1'b1;
        if (spi_eob && (state != S_IDLE) && (byte_idx != 8'hFF))
          byte_idx <= byte_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed frames from the test plan followed by
// random frames. Expected MISO bytes and state come from a frame-level model.
module tb_spi_frame_ctrl;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int FDEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               spi_busy;
  logic               spi_eob;
  logic [7:0]         spi_rx;
  logic [7:0]         spi_tx;
  logic               spi_err;
  logic [7:0]         fifo_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_rd;
  logic [8*NREGS-1:0] cfg_regs;
  logic               cfg_wr;
  logic [7:0]         frame_cnt;
  logic [2:0]         fsm_state;

  // Clock and DUT.
  always #5 clk = ~clk;

  spi_frame_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .spi_busy(spi_busy), .spi_eob(spi_eob),
    .spi_rx(spi_rx), .spi_tx(spi_tx), .spi_err(spi_err),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rd(fifo_rd), .cfg_regs(cfg_regs), .cfg_wr(cfg_wr),
    .frame_cnt(frame_cnt), .fsm_state(fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level reference state.
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_fc;
  logic       m_unf, m_err;

  // Capture FIFO environment and pulse counters.
  logic [7:0] fifo_q[$];
  int         rd_pulses = 0;
  int         wr_pulses = 0;
  int         bad_pop   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = (fifo_q.size() >= FDEPTH);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Advance one cycle, observe pulses at the negedge and service the FIFO.
  task automatic tick();
    @(negedge clk);
    if (cfg_wr) wr_pulses++;
    if (fifo_rd) begin
      rd_pulses++;
      if (fifo_q.size() == 0) bad_pop++;
      else void'(fifo_q.pop_front());
    end
    fifo_sync();
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Drive one frame, checking each MISO byte against the model.
  task automatic run_frame(input logic [7:0] fb[$], input bit drop_last);
    logic [7:0] exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] v;
    logic [4:0] cmd;
    logic       rd, valid;
    logic [AW-1:0] a;
    int n, exp_wr, exp_rd, wr0, rd0;
    n = fb.size();
    fq = fifo_q;
    cmd = fb[0][4:0];
    rd  = fb[0][6];
    valid = (cmd == 5'd0) || (cmd == 5'd1) || (((cmd == 5'd2) || (cmd == 5'd3)) && rd);
    exp_wr = 0;
    exp_rd = 0;
    a = '0;
    exp_q.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      v = 8'h00;
      if (!valid) begin
        if (k == 0) m_err = 1'b1;
      end else if (cmd == 5'd1) begin
        if (k == 1) begin
          a = fb[1][AW-1:0];
          if (rd) v = m_regs[a];
        end else if (k >= 2) begin
          if (!rd) begin
            m_regs[a] = fb[k];
            exp_wr++;
          end
          a = a + 1'b1;
          if (rd) v = m_regs[a];
        end
      end else if (cmd == 5'd2) begin
        if (!(drop_last && k == n-1)) begin
          if (fq.size() > 0) begin
            v = fq.pop_front();
            exp_rd++;
          end else m_unf = 1'b1;
        end
      end else if (cmd == 5'd3) begin
        if (!(drop_last && k == n-1)) begin
          v = {fq.size() == 0, fq.size() >= FDEPTH, m_unf, m_err, m_fc[3:0]};
          m_unf = 1'b0;
          m_err = 1'b0;
        end
      end
      if (k < n-1) exp_q.push_back(v);
    end
    if (valid) m_fc = m_fc + 8'd1;

    wr0 = wr_pulses;
    rd0 = rd_pulses;
    spi_busy = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2, 4)) tick();
      check($sformatf("miso[%0d] hdr=%0h", k, fb[0]), spi_tx, exp_q[k]);
      if (k > 0) check("err_in_frame", spi_err, !valid);
      spi_rx  = fb[k];
      spi_eob = 1'b1;
      if (drop_last && k == n-1) spi_busy = 1'b0;
      tick();
      spi_eob = 1'b0;
      spi_rx  = 8'($urandom_range(0, 255));
      if (k == 0) check("err_after_hdr", spi_err, !valid);
    end
    if (!drop_last) begin
      repeat (2) tick();
      check("err_before_ss", spi_err, !valid);
      spi_busy = 1'b0;
    end
    repeat (3) tick();
    check("err_after_ss", spi_err, 1'b0);
    check("state_idle", fsm_state, 3'd0);
    check("tx_idle", spi_tx, 8'h00);
    check("frame_cnt", frame_cnt, m_fc);
    check("cfg_regs", cfg_regs, model_flat());
    check("cfg_wr_pulses", wr_pulses - wr0, exp_wr);
    check("fifo_rd_pulses", rd_pulses - rd0, exp_rd);
    check("fifo_level", fifo_q.size(), fq.size());
    check("no_empty_pop", bad_pop, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_fc  = 8'h00;
    m_unf = 1'b0;
    m_err = 1'b0;
  endtask

  logic [7:0] f[$];
  logic [7:0] hdr;

  initial begin
    rst      = 1'b0;
    spi_busy = 1'b0;
    spi_eob  = 1'b0;
    spi_rx   = 8'h00;
    fifo_sync();
    model_reset();
    repeat (3) tick();
    check("rst_regs", cfg_regs, 64'h0);
    check("rst_tx", spi_tx, 8'h00);
    check("rst_err", spi_err, 1'b0);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_cfg_wr", cfg_wr, 1'b0);
    check("rst_fcnt", frame_cnt, 8'h00);
    check("rst_state", fsm_state, 3'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Write burst with address wrap.
    f = '{8'h01, 8'h06, 8'hAA, 8'hBB, 8'hCC};
    run_frame(f, 1'b0);
    check("wr_reg6", cfg_regs[55:48], 8'hAA);
    check("wr_reg0", cfg_regs[7:0], 8'hCC);
    // Read-back.
    f = '{8'h41, 8'h06, 8'h5C, 8'h3E};
    run_frame(f, 1'b0);
    // FIFO drain with underflow.
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_sync();
    f = '{8'h42, 8'h00, 8'h00, 8'h00};
    run_frame(f, 1'b0);
    // Status read clears UNF; repeat shows it cleared.
    f = '{8'h43, 8'h00};
    run_frame(f, 1'b0);
    f = '{8'h43, 8'h00};
    run_frame(f, 1'b0);
    // Bad command, then status shows ERR.
    f = '{8'h1F, 8'h12, 8'h34};
    run_frame(f, 1'b0);
    f = '{8'h43, 8'h00};
    run_frame(f, 1'b0);
    // FIFO/STATUS with rd=0 are errors too.
    f = '{8'h02, 8'h00};
    run_frame(f, 1'b0);
    // Write whose last strobe coincides with SS release.
    f = '{8'h01, 8'h03, 8'h5A};
    run_frame(f, 1'b1);
    check("drop_wr_reg3", cfg_regs[31:24], 8'h5A);

    // Random frames.
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++)
        if (fifo_q.size() < FDEPTH) fifo_q.push_back(8'($urandom_range(0, 255)));
      fifo_sync();
      case ($urandom_range(0, 8))
        0:       hdr = 8'h00;
        1:       hdr = 8'h01;
        2:       hdr = 8'h41;
        3:       hdr = 8'h42;
        4:       hdr = 8'h43;
        5:       hdr = 8'hE2;
        6:       hdr = 8'h81;
        7:       hdr = 8'h03;
        default: hdr = 8'($urandom_range(0, 255));
      endcase
      f.delete();
      f.push_back(hdr);
      for (int j = 1; j < $urandom_range(1, 6); j++) f.push_back(8'($urandom_range(0, 255)));
      run_frame(f, 1'b0);
    end

    // Make the register bank non-zero, then reset asynchronously after ARG.
    f = '{8'h01, 8'h02, 8'h77, 8'h88};
    run_frame(f, 1'b0);
    spi_busy = 1'b1;
    tick();
    repeat (2) tick();
    spi_rx = 8'h01; spi_eob = 1'b1; tick(); spi_eob = 1'b0;
    repeat (2) tick();
    spi_rx = 8'h05; spi_eob = 1'b1; tick(); spi_eob = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_regs", cfg_regs, 64'h0);
    check("arst_tx", spi_tx, 8'h00);
    check("arst_state", fsm_state, 3'd0);
    check("arst_fcnt", frame_cnt, 8'h00);
    check("arst_cfg_wr", cfg_wr, 1'b0);
    check("arst_fifo_rd", fifo_rd, 1'b0);
    model_reset();
    spi_busy = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    f = '{8'h41, 8'h00, 8'h00, 8'h00};
    run_frame(f, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
